// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic datapath (adder/subtractor).
// Provides the top-level sequencing states, the NB/B borrow-state encoding
// (identical to the adder's carry-state encoding) and the per-bit
// full-subtractor equations used by both the cell and the word-level logic.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } top_state_e;

    localparam logic NB = 1'b0;  // no borrow pending
    localparam logic B  = 1'b1;  // borrow pending

    // Difference bit of x - y - q.
    function automatic logic sub_diff(input logic x, input logic y, input logic q);
        return x ^ y ^ q;
    endfunction

    // Borrow out of x - y - q: borrow when y exceeds x, or when they are
    // equal and a borrow is already pending.
    function automatic logic sub_borrow(input logic x, input logic y, input logic q);
        return (~x & y) | (~(x ^ y) & q);
    endfunction

    // Signed overflow of a - b: only possible for operands of opposite sign,
    // and present when the result sign differs from the minuend sign.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/serial_word_sub_if.sv
// Operand and result handshake bundle for serial_word_sub.
//   in_valid/in_ready : operand channel carrying a, b, bin
//   out_valid/out_ready : result channel carrying diff, borrow_out, overflow
// slave modport is the subtractor's view, master is the producer/consumer view.
interface serial_word_sub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, borrow_out, overflow
    );

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, borrow_out, overflow
    );
endinterface

// File: rtl/serial_word_sub_cell.sv
// serial_sub_cell: one full-subtractor bit plus the NB/B borrow flop.
//   clk, reset : clock, async active-low reset (borrow -> NB)
//   load       : seed the borrow state with load_val (borrow-in at bit 0)
//   load_val   : initial borrow state
//   en         : advance the borrow state with this bit's borrow-out
//   x, y       : minuend / subtrahend bits
//   d          : difference bit (combinational)
//   q          : current borrow state
module serial_sub_cell
    import serial_arith_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic load_val,
    input  logic en,
    input  logic x,
    input  logic y,
    output logic d,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (en) begin
            q_d = sub_borrow(x, y, q_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= NB;
        end else begin
            q_q <= q_d;
        end
    end

    assign d = sub_diff(x, y, q_q);
    assign q = q_q;

endmodule

// File: rtl/serial_word_sub.sv
// serial_word_sub: bit-serial WIDTH-bit subtractor, diff = a - b - bin.
// Operands are accepted in IDLE, shifted LSB-first through serial_sub_cell
// one bit per clock, and the reassembled result is presented in DONE until
// the consumer takes it.
//   clk, reset  : clock, async active-low reset
//   io (slave)  : operand and result handshakes (see serial_word_sub_if)
//   busy        : high while bits are being shifted
//   ser_diff    : difference bit produced this cycle
//   ser_borrow  : current borrow state (0 = NB, 1 = B)
module serial_word_sub
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    serial_word_sub_if.slave   io,
    output logic               busy,
    output logic               ser_diff,
    output logic               ser_borrow
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    top_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;

    logic cell_load;
    logic cell_en;
    logic cell_d;
    logic cell_q;

    serial_sub_cell u_cell (
        .clk      (clk),
        .reset    (reset),
        .load     (cell_load),
        .load_val (io.bin),
        .en       (cell_en),
        .x        (a_sh_q[0]),
        .y        (b_sh_q[0]),
        .d        (cell_d),
        .q        (cell_q)
    );

    always_comb begin
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        res_sh_d     = res_sh_q;
        cnt_d        = cnt_q;
        a_msb_d      = a_msb_q;
        b_msb_d      = b_msb_q;
        out_valid_d  = out_valid_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        overflow_d   = overflow_q;
        busy_d       = busy_q;
        cell_load    = 1'b0;
        cell_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    a_sh_d    = io.a;
                    b_sh_d    = io.b;
                    a_msb_d   = io.a[WIDTH-1];
                    b_msb_d   = io.b[WIDTH-1];
                    cnt_d     = '0;
                    cell_load = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                cell_en  = 1'b1;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = {cell_d, res_sh_q[WIDTH-1:1]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // Last bit: publish the word; the borrow-out is the
                    // borrow this edge loads into the cell.
                    cnt_d        = '0;
                    busy_d       = 1'b0;
                    out_valid_d  = 1'b1;
                    diff_d       = res_sh_d;
                    borrow_out_d = sub_borrow(a_sh_q[0], b_sh_q[0], cell_q);
                    overflow_d   = sub_ovf(a_msb_q, b_msb_q, cell_d);
                    state_d      = DONE;
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            res_sh_q     <= '0;
            cnt_q        <= '0;
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            res_sh_q     <= res_sh_d;
            cnt_q        <= cnt_d;
            a_msb_q      <= a_msb_d;
            b_msb_q      <= b_msb_d;
            out_valid_q  <= out_valid_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
        end
    end

    assign io.in_ready   = (state_q == IDLE);
    assign io.out_valid  = out_valid_q;
    assign io.diff       = diff_q;
    assign io.borrow_out = borrow_out_q;
    assign io.overflow   = overflow_q;
    assign busy          = busy_q;
    // The serial tap only carries a meaningful bit while shifting.
    assign ser_diff      = busy_q & cell_d;
    assign ser_borrow    = cell_q;

endmodule

// File: doc/serial_word_sub.md
Name: serial_word_sub

Overview:
Bit-serial word subtractor: the inverse operation to the team's bit-serial carry adder. Accepts two WIDTH-bit parallel operands plus a borrow-in over a valid/ready handshake. Shifts them LSB-first through a two-state borrow FSM, one bit per clock. Reassembles the difference into a parallel word with borrow-out and signed overflow, returned over a second valid/ready handshake. Sits alongside the serial adder as the subtract half of the bit-serial arithmetic datapath; chainable through bin/borrow_out.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset; low clears all state immediately.
in_valid  input  1  operands a, b, bin valid.
in_ready  output  1  block can accept operands (state IDLE).
a  input  WIDTH  minuend.
b  input  WIDTH  subtrahend.
bin  input  1  borrow-in, applied at bit 0.
out_valid  output  1  diff, borrow_out and overflow valid.
out_ready  input  1  consumer accepts result.
diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
borrow_out  output  1  borrow out of MSB (unsigned a < b + bin).
overflow  output  1  signed two's-complement overflow.
busy  output  1  high in SHIFT.
ser_diff  output  1  difference bit produced this cycle (debug/serial tap).
ser_borrow  output  1  current borrow-FSM state (0 = NB, 1 = B).

Behaviour:
- Reset (reset low, async): state IDLE, borrow FSM NB, bit counter 0, shift registers 0.
- Reset output values: out_valid 0, diff 0, borrow_out 0, overflow 0, busy 0, ser_diff 0, ser_borrow 0. in_ready 1 (decoded from IDLE).
- Top FSM: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&in_ready at edge t:
  - load a_sh<=a and b_sh<=b;
  - borrow FSM <= bin (B if 1, else NB);
  - store a[WIDTH-1] and b[WIDTH-1] for overflow;
  - counter<=0; go to SHIFT.
- SHIFT, one bit per edge, LSB first:
  - x=a_sh[0], y=b_sh[0], q=borrow state;
  - ser_diff = x^y^q;
  - next borrow = (~x&y) | (~(x^y)&q);
  - borrow FSM: NB->B on next borrow 1, B->NB on next borrow 0, else hold;
  - a_sh and b_sh shift right; result register shifts right with ser_diff entering the MSB;
  - counter++.
- Exit SHIFT: after the edge processing bit WIDTH-1 (edge t+WIDTH):
  - state DONE; out_valid=1;
  - diff = full result; borrow_out = final borrow state;
  - overflow = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb).
- Latency: out_valid high in the cycle following edge t+WIDTH, i.e. WIDTH cycles after the accepting edge.
- DONE: in_ready=0. diff, borrow_out and overflow held stable while out_valid&!out_ready. On out_valid&out_ready: out_valid<=0, state IDLE. Outputs keep their last values until the next result.
- No input accepted in SHIFT or DONE; in_valid is ignored there. Back-to-back throughput: one result per WIDTH+2 cycles.
- bin applies only at bit 0. borrow_out and overflow are never updated mid-operation.
- Reset asserted mid-SHIFT or in DONE: operation is discarded, nothing is emitted, and the first operand after reset release computes correctly.

Decomposition:
- Shared package serial_arith_pkg: top-state constants IDLE=2'd0, SHIFT=2'd1, DONE=2'd2; borrow-state constants NB=1'b0, B=1'b1 (same encoding as the adder's carry states).
- One sub-module, serial_sub_cell: combinational full-subtractor bit plus the NB/B borrow flop. Ports: clk, reset, load, load_val, en, x, y, d, q.

Test Plan:
- WIDTH=8, a=8'h35, b=8'h12, bin=0 -> diff=8'h23, borrow_out=0, overflow=0; out_valid exactly 8 cycles after accept.
- a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, borrow_out=1, overflow=0; ser_borrow=1 from bit 0 onward.
- a=8'h80, b=8'h01, bin=0 -> diff=8'h7F, borrow_out=0, overflow=1.
- a=8'h10, b=8'h0F, bin=1 -> diff=8'h00, borrow_out=0, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles and pulse in_valid with a new operand -> out_valid/diff stable, in_ready=0, new operand ignored. Release out_ready -> IDLE next cycle; the next op then completes correctly.
- reset low while at bit 4 of an op -> all outputs at reset values immediately, in_ready=1. After release, a=8'hFF, b=8'hFF -> diff=8'h00, borrow_out=0.
